// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex-to-segment decode for the 7-segment scan controller.
package seg7_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] pattern;
        case (nibble)
            4'h0:    pattern = 7'h40;
            4'h1:    pattern = 7'h79;
            4'h2:    pattern = 7'h24;
            4'h3:    pattern = 7'h30;
            4'h4:    pattern = 7'h19;
            4'h5:    pattern = 7'h12;
            4'h6:    pattern = 7'h02;
            4'h7:    pattern = 7'h78;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h10;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h03;
            4'hC:    pattern = 7'h46;
            4'hD:    pattern = 7'h21;
            4'hE:    pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-segment decoder built on the shared package function.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with frame-synchronous value
// commit, per-slot anode guard time and optional leading-zero suppression.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV      = 100_000,
    parameter int GUARD_CYCLES     = 16,
    parameter int BLANK_LEAD_ZEROS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] value_in,
    input  logic        value_load,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int             CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  GUARD_END = CW'(GUARD_CYCLES);

    logic [CW-1:0] cnt;
    digit_state_t  state;
    digit_state_t  state_next;
    logic [1:0]    idx;

    logic [15:0]   pending;
    logic [15:0]   display;
    logic          pend_flag;

    logic          slot_wrap;
    logic          frame_wrap;
    logic          commit_now;

    logic [3:0]    lz_blank;
    logic [3:0]    digit_nibble;
    logic [6:0]    digit_seg;

    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;
    logic          frame_done_next;

    assign idx          = state;
    assign slot_wrap    = (cnt == CNT_LAST);
    assign frame_wrap   = slot_wrap && (state == DIG3);
    assign commit_now   = !enable || frame_wrap;
    assign digit_nibble = display[{idx, 2'b00} +: 4];

    hex_to_seg7 u_decode (
        .nibble (digit_nibble),
        .seg    (digit_seg)
    );

    // Slot counter: runs through one digit slot and restarts; held at zero while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || slot_wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Digit FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIG0;
        end else begin
            state <= state_next;
        end
    end

    // Next digit: step once per slot wrap, park on DIG0 while disabled.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = DIG0;
        end else if (slot_wrap) begin
            case (state)
                DIG0:    state_next = DIG1;
                DIG1:    state_next = DIG2;
                DIG2:    state_next = DIG3;
                default: state_next = DIG0;
            endcase
        end
    end

    // Double buffer: loads go to pending, which is copied to display only at a frame wrap or while dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            display   <= '0;
            pend_flag <= 1'b0;
        end else begin
            if (value_load) begin
                pending <= value_in;
            end
            if (commit_now) begin
                if (value_load) begin
                    display <= value_in;
                end else if (pend_flag) begin
                    display <= pending;
                end
                pend_flag <= 1'b0;
            end else if (value_load) begin
                pend_flag <= 1'b1;
            end
        end
    end

    // Leading-zero mask: digit k goes dark when it and every digit to its left are zero.
    always_comb begin
        lz_blank = 4'b0000;
        if (BLANK_LEAD_ZEROS != 0) begin
            lz_blank[1] = (display[15:4]  == 12'h000);
            lz_blank[2] = (display[15:8]  == 8'h00);
            lz_blank[3] = (display[15:12] == 4'h0);
        end
    end

    // Pin values for the current counter/state, all dark during the guard window or when disabled.
    always_comb begin
        an_next         = AN_OFF;
        seg_next        = SEG_BLANK;
        dp_next         = 1'b1;
        frame_done_next = 1'b0;
        if (enable) begin
            frame_done_next = frame_wrap;
            if (cnt >= GUARD_END) begin
                an_next  = ~(4'b0001 << idx);
                seg_next = lz_blank[idx] ? SEG_BLANK : digit_seg;
                dp_next  = ~dp_in[idx];
            end
        end
    end

    // Output registers give glitch-free pins one cycle behind the counter and state.
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a short slot (8 cycles, 2 guard cycles).
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] value_in;
    logic        value_load;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int n_checks;
    int n_fail;

    seg7_scan_ctrl #(
        .REFRESH_DIV      (8),
        .GUARD_CYCLES     (2),
        .BLANK_LEAD_ZEROS (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .value_in   (value_in),
        .value_load (value_load),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic r, input logic en, input logic ld,
                                 input logic [15:0] val, input logic [3:0] dps);
        rst        = r;
        enable     = en;
        value_load = ld;
        value_in   = val;
        dp_in      = dps;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                               input logic e_dp, input logic e_fd);
        n_checks++;
        assert (an === e_an) else begin
            n_fail++;
            $error("[TB] FAIL %s an: observed %h expected %h", tag, an, e_an);
        end
        n_checks++;
        assert (seg === e_seg) else begin
            n_fail++;
            $error("[TB] FAIL %s seg: observed %h expected %h", tag, seg, e_seg);
        end
        n_checks++;
        assert (dp === e_dp) else begin
            n_fail++;
            $error("[TB] FAIL %s dp: observed %b expected %b", tag, dp, e_dp);
        end
        n_checks++;
        assert (frame_done === e_fd) else begin
            n_fail++;
            $error("[TB] FAIL %s frame_done: observed %b expected %b", tag, frame_done, e_fd);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 4'b0000);
        tick(3);
        checkOutput("reset", 4'hF, 7'h7F, 1'b1, 1'b0);

        // First frame shows the reset display value; the 1234 load waits for the wrap
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234, 4'b0000);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h1234, 4'b0000);
        checkOutput("f0_cnt0", 4'hF, 7'h7F, 1'b1, 1'b0);
        tick(1);
        checkOutput("f0_cnt1_guard", 4'hF, 7'h7F, 1'b1, 1'b0);
        tick(1);
        checkOutput("f0_dig0", 4'hE, 7'h40, 1'b1, 1'b0);
        tick(5);
        checkOutput("f0_dig0_end", 4'hE, 7'h40, 1'b1, 1'b0);
        tick(1);
        checkOutput("f0_dig1_guard", 4'hF, 7'h7F, 1'b1, 1'b0);
        tick(2);
        checkOutput("f0_dig1_lz", 4'hD, 7'h7F, 1'b1, 1'b0);
        tick(21);
        checkOutput("first_wrap", 4'h7, 7'h7F, 1'b1, 1'b1);

        // Frame 1 shows 1234
        tick(1);
        checkOutput("f1_guard", 4'hF, 7'h7F, 1'b1, 1'b0);
        tick(2);
        checkOutput("f1_dig0", 4'hE, 7'h19, 1'b1, 1'b0);
        tick(6);
        checkOutput("f1_dig1_guard", 4'hF, 7'h7F, 1'b1, 1'b0);
        tick(2);
        checkOutput("f1_dig1", 4'hD, 7'h30, 1'b1, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b1, 16'hABCD, 4'b0000);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'hABCD, 4'b0000);
        checkOutput("load_abcd_hidden", 4'hD, 7'h30, 1'b1, 1'b0);
        tick(7);
        checkOutput("f1_dig2", 4'hB, 7'h24, 1'b1, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b1, 16'h00F0, 4'b0000);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h00F0, 4'b0000);
        checkOutput("load_00f0_hidden", 4'hB, 7'h24, 1'b1, 1'b0);
        tick(7);
        checkOutput("f1_dig3", 4'h7, 7'h79, 1'b1, 1'b0);
        tick(5);
        checkOutput("second_wrap", 4'h7, 7'h79, 1'b1, 1'b1);

        // Frame 2 shows 00F0 (last load wins)
        tick(3);
        checkOutput("f2_dig0", 4'hE, 7'h40, 1'b1, 1'b0);
        tick(8);
        checkOutput("f2_dig1", 4'hD, 7'h0E, 1'b1, 1'b0);
        tick(8);
        checkOutput("f2_dig2_lz", 4'hB, 7'h7F, 1'b1, 1'b0);
        tick(8);
        checkOutput("f2_dig3_lz", 4'h7, 7'h7F, 1'b1, 1'b0);

        // Load during the wrap cycle bypasses into the display
        tick(4);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0005, 4'b0000);
        tick(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0005, 4'b0000);
        checkOutput("wrap_load", 4'h7, 7'h7F, 1'b1, 1'b1);
        n_checks++;
        assert (dut.pend_flag === 1'b0) else begin
            n_fail++;
            $error("[TB] FAIL pend_flag_bypass: observed %b expected 0", dut.pend_flag);
        end
        tick(3);
        checkOutput("f3_dig0", 4'hE, 7'h12, 1'b1, 1'b0);
        tick(8);
        checkOutput("f3_dig1_lz", 4'hD, 7'h7F, 1'b1, 1'b0);

        // Decimal point on digit 2 only, live and not blanked by leading-zero rule
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0005, 4'b0100);
        tick(1);
        checkOutput("dp_other_digit", 4'hD, 7'h7F, 1'b1, 1'b0);
        tick(7);
        checkOutput("dp_dig2", 4'hB, 7'h7F, 1'b0, 1'b0);
        tick(5);
        checkOutput("dp_dig2_end", 4'hB, 7'h7F, 1'b0, 1'b0);
        tick(1);
        checkOutput("dp_guard", 4'hF, 7'h7F, 1'b1, 1'b0);
        tick(2);
        checkOutput("dp_dig3", 4'h7, 7'h7F, 1'b1, 1'b0);
        tick(24);
        checkOutput("f4_dig2", 4'hB, 7'h7F, 1'b0, 1'b0);

        // Disable mid-DIG2 for five cycles, loading a value while dark
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0005, 4'b0100);
        tick(1);
        checkOutput("disable", 4'hF, 7'h7F, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0042, 4'b0100);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0042, 4'b0100);
        checkOutput("disable_load", 4'hF, 7'h7F, 1'b1, 1'b0);
        tick(3);
        checkOutput("disable_hold", 4'hF, 7'h7F, 1'b1, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0042, 4'b0100);
        tick(1);
        checkOutput("reenable_cnt0", 4'hF, 7'h7F, 1'b1, 1'b0);
        tick(1);
        checkOutput("reenable_cnt1", 4'hF, 7'h7F, 1'b1, 1'b0);
        tick(1);
        checkOutput("reenable_dig0", 4'hE, 7'h24, 1'b1, 1'b0);
        tick(8);
        checkOutput("reenable_dig1", 4'hD, 7'h19, 1'b1, 1'b0);
        tick(8);
        checkOutput("reenable_dig2_lz", 4'hB, 7'h7F, 1'b0, 1'b0);
        tick(8);
        checkOutput("pre_reset_dig3", 4'h7, 7'h7F, 1'b1, 1'b0);

        // Reset in the middle of DIG3
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0042, 4'b0100);
        tick(1);
        checkOutput("mid_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
        n_checks++;
        assert (dut.display === 16'h0000) else begin
            n_fail++;
            $error("[TB] FAIL mid_reset_display: observed %h expected 0000", dut.display);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 4'b0000);
        tick(3);
        checkOutput("post_reset_dig0", 4'hE, 7'h40, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
